ped_request_scheduler: RTL and testbench
========================================

Name: ped_request_scheduler

Overview:
Shares the intersection's single pedestrian phase among NUM_BUTTONS crosswalk push-buttons. It synchronises and debounces each raw button, then holds a per-corner pending request and lights that corner's WAIT lamp. It issues one-cycle pedestrian_request pulses to the traffic light controller, tracks the controller's WALK indication and enforces a cooldown between pedestrian phases. It sits between the board-level buttons and the controller's pedestrian_request input, in the same clock domain as the controller.

Parameters:
NUM_BUTTONS, 4, number of crosswalk buttons (1..8)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (>=2)
COOLDOWN_CYCLES, 20, minimum cycles after WALK ends before the next request may issue (>=1)
REQ_TIMEOUT, 64, cycles spent in WAIT_WALK without WALK before the request is re-issued (>=2)

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
button_raw  in  NUM_BUTTONS  raw asynchronous button levels, 1 = pressed
ped_walk  in  1  1 while the controller shows WALK (ped_light == 2'b10); same clock domain
enable  in  1  permits new requests to issue; gates IDLE->ISSUE only
pedestrian_request  out  1  one-cycle request pulse to the controller
wait_lamp  out  NUM_BUTTONS  per-corner WAIT lamp, equal to the pending bits
served_mask  out  NUM_BUTTONS  snapshot of pending taken at WALK entry; held until the next WALK entry
sched_state  out  3  current FSM state code
issue_count  out  8  count of ISSUE cycles, saturating at 255
walk_timeout  out  1  one-cycle pulse when a WAIT_WALK timeout forces a re-issue

Behaviour:
- Reset values: all outputs 0; sched_state = IDLE; sync flops, debounce counters, pending and timers all cleared. Reset mid-operation abandons any request; pedestrian_request drops immediately (asynchronous).
- Per button: 2-flop synchroniser, then debouncer. The debounce counter clears whenever the synced sample equals the debounced level. After DEBOUNCE_CYCLES consecutive differing samples, the debounced level flips.
- A rising edge of the debounced level is a press event. Exactly one event per press; holding the button generates nothing more.
- Latency: pending[i] = 1 exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples button_raw[i] high. A pulse shorter than DEBOUNCE_CYCLES synced cycles is ignored.
- A press event sets pending[i]. pending is cleared only on WALK entry.
- FSM states (package encodings): IDLE=0, ISSUE=1, WAIT_WALK=2, WALK=3, COOLDOWN=4. Unused codes go to IDLE.
  - IDLE: if enable && |pending, go to ISSUE.
  - ISSUE: one cycle; pedestrian_request=1 in this cycle only; issue_count++ (saturating); go to WAIT_WALK and clear the timeout counter.
  - WAIT_WALK:
    - if ped_walk, go to WALK; served_mask <= pending; pending <= 0 (same edge).
    - else if the timeout counter reaches REQ_TIMEOUT-1, pulse walk_timeout and go to ISSUE.
    - enable is ignored here.
  - WALK: stay while ped_walk=1. Press events are discarded (corner is already walking). When ped_walk=0, go to COOLDOWN and clear the cooldown counter.
  - COOLDOWN: press events set pending normally; no issue. After COOLDOWN_CYCLES cycles, go to IDLE.
- Simultaneous events:
  - Press event on the WALK-entry edge: the clear wins and the press is discarded.
  - Press event on any other edge is OR-ed into pending.
- ped_walk asserted while in IDLE/ISSUE/COOLDOWN (WALK granted by an external request): no state change, no pending clear.
- pedestrian_request is registered and never high for two consecutive cycles.

Decomposition:
- Package ped_sched_pkg: FSM state localparams (3-bit codes above), ISSUE_COUNT_MAX=255.
- Sub-module button_debouncer (synchroniser + debounce counter + press-event pulse, parameter DEBOUNCE_CYCLES), instantiated NUM_BUTTONS times via generate.
- The FSM, pending/served registers, timers and counter live in the top module.

Test Plan:
- Defaults. button_raw[2] high from edge 0 and held; ped_walk=0; enable=1 -> wait_lamp=4'b0100 after edge 6; sched_state=ISSUE after edge 7, with pedestrian_request=1 for exactly that cycle; issue_count=1.
- button_raw[0] glitch high for 3 cycles -> wait_lamp stays 0, no pedestrian_request, sched_state stays IDLE.
- Buttons 1 and 3 pressed; ped_walk raised 5 cycles after ISSUE and held 5 cycles:
  - on WALK entry: served_mask=4'b1010, wait_lamp=0;
  - button 0 pressed during WALK -> no lamp;
  - COOLDOWN lasts 20 cycles, then IDLE.
- Press button 0 with ped_walk held 0 -> walk_timeout pulses 64 cycles after entering WAIT_WALK, pedestrian_request re-issues, issue_count=2.
- enable=0 with pending=4'b0001 -> stays IDLE, lamp lit. Raise enable -> ISSUE on the next edge.
- Assert reset during WAIT_WALK -> all outputs 0 and sched_state=IDLE immediately. After release, no request until a new press.

Source files
------------

// File: rtl/ped_sched_pkg.sv
// rtl/ped_sched_pkg.sv - shared state codes and helpers for the pedestrian request scheduler
package ped_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_WALK = 3'd2,
        ST_WALK      = 3'd3,
        ST_COOLDOWN  = 3'd4
    } sched_state_t;

    localparam int ISSUE_COUNT_MAX = 255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'(ISSUE_COUNT_MAX)) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser, debounce counter and one-cycle press pulse
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= button_raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ped_request_scheduler.sv
// rtl/ped_request_scheduler.sv - arbitrates crosswalk buttons into pedestrian requests for the controller
module ped_request_scheduler
    import ped_sched_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 20,
    parameter int REQ_TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button_raw,
    input  logic                   ped_walk,
    input  logic                   enable,
    output logic                   pedestrian_request,
    output logic [NUM_BUTTONS-1:0] wait_lamp,
    output logic [NUM_BUTTONS-1:0] served_mask,
    output logic [2:0]             sched_state,
    output logic [7:0]             issue_count,
    output logic                   walk_timeout
);
    localparam int TW  = $clog2(REQ_TIMEOUT);
    localparam int CDW = $clog2(COOLDOWN_CYCLES + 1);

    logic [NUM_BUTTONS-1:0] press;
    logic [NUM_BUTTONS-1:0] pending;
    logic [TW-1:0]          to_cnt;
    logic [CDW-1:0]         cd_cnt;
    sched_state_t           state;
    logic                   walk_entry;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk       (clk),
            .reset     (reset),
            .button_raw(button_raw[i]),
            .press     (press[i])
        );
    end

    assign walk_entry  = (state == ST_WAIT_WALK) && ped_walk;
    assign wait_lamp   = pending;
    assign sched_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            pending            <= '0;
            served_mask        <= '0;
            to_cnt             <= '0;
            cd_cnt             <= '0;
            issue_count        <= 8'd0;
            pedestrian_request <= 1'b0;
            walk_timeout       <= 1'b0;
        end else begin
            pedestrian_request <= 1'b0;
            walk_timeout       <= 1'b0;

            // WALK entry clears everything; presses while walking are already served.
            if (walk_entry) begin
                pending <= '0;
            end else if (state != ST_WALK) begin
                pending <= pending | press;
            end

            case (state)
                ST_IDLE: begin
                    if (enable && |pending) begin
                        state              <= ST_ISSUE;
                        pedestrian_request <= 1'b1;
                        issue_count        <= sat_inc8(issue_count);
                    end
                end
                ST_ISSUE: begin
                    state  <= ST_WAIT_WALK;
                    to_cnt <= '0;
                end
                ST_WAIT_WALK: begin
                    if (ped_walk) begin
                        state       <= ST_WALK;
                        served_mask <= pending;
                    end else if (to_cnt == TW'(REQ_TIMEOUT - 1)) begin
                        state              <= ST_ISSUE;
                        walk_timeout       <= 1'b1;
                        pedestrian_request <= 1'b1;
                        issue_count        <= sat_inc8(issue_count);
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WALK: begin
                    if (!ped_walk) begin
                        state  <= ST_COOLDOWN;
                        cd_cnt <= '0;
                    end
                end
                ST_COOLDOWN: begin
                    if (cd_cnt == CDW'(COOLDOWN_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ped_request_scheduler.sv
// tb/tb_ped_request_scheduler.sv - directed self-checking bench for ped_request_scheduler
module tb_ped_request_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] button_raw;
    logic       ped_walk;
    logic       enable;
    logic       pedestrian_request;
    logic [3:0] wait_lamp;
    logic [3:0] served_mask;
    logic [2:0] sched_state;
    logic [7:0] issue_count;
    logic       walk_timeout;

    int n_cmp;
    int n_err;
    int req_total;
    int dbl_req;
    logic prev_req;

    ped_request_scheduler #(
        .NUM_BUTTONS(4),
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_CYCLES(20),
        .REQ_TIMEOUT(64)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .button_raw        (button_raw),
        .ped_walk          (ped_walk),
        .enable            (enable),
        .pedestrian_request(pedestrian_request),
        .wait_lamp         (wait_lamp),
        .served_mask       (served_mask),
        .sched_state       (sched_state),
        .issue_count       (issue_count),
        .walk_timeout      (walk_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (prev_req && pedestrian_request) dbl_req++;
            if (pedestrian_request) req_total++;
            prev_req = pedestrian_request;
        end
    endtask

    task automatic wait_issue(input string tag, input int budget);
        int ok;
        ok = 0;
        for (int k = 0; k < budget && ok == 0; k++) begin
            tick(1);
            if (sched_state == 3'd1) ok = 1;
        end
        chk(tag, ok, 1);
    endtask

    int r0;

    initial begin
        n_cmp = 0; n_err = 0; req_total = 0; dbl_req = 0; prev_req = 1'b0;
        reset = 1'b1; button_raw = 4'b0; ped_walk = 1'b0; enable = 1'b1;
        tick(3);
        chk("rst_state", sched_state, 0);
        chk("rst_req", pedestrian_request, 0);
        chk("rst_lamp", wait_lamp, 0);
        chk("rst_served", served_mask, 0);
        chk("rst_count", issue_count, 0);
        chk("rst_timeout", walk_timeout, 0);
        reset = 1'b0;
        tick(2);

        // Button 2 held: first sample on edge 0, lamp after edge 6, ISSUE after edge 7.
        button_raw = 4'b0100;
        tick(6);
        chk("t1_lamp_e5", wait_lamp, 4'b0000);
        tick(1);
        chk("t1_lamp_e6", wait_lamp, 4'b0100);
        chk("t1_state_e6", sched_state, 0);
        tick(1);
        chk("t1_state_e7", sched_state, 1);
        chk("t1_req_e7", pedestrian_request, 1);
        chk("t1_count", issue_count, 1);
        tick(1);
        chk("t1_state_e8", sched_state, 2);
        chk("t1_req_e8", pedestrian_request, 0);
        ped_walk = 1'b1; button_raw = 4'b0;
        tick(1);
        chk("t1_walk", sched_state, 3);
        chk("t1_served", served_mask, 4'b0100);
        chk("t1_lamp_clr", wait_lamp, 0);
        ped_walk = 1'b0;
        tick(1);
        chk("t1_cool", sched_state, 4);
        tick(20);
        chk("t1_idle", sched_state, 0);

        // 3-cycle glitch on button 0 must be filtered.
        r0 = req_total;
        button_raw = 4'b0001;
        tick(3);
        button_raw = 4'b0000;
        tick(12);
        chk("t2_lamp", wait_lamp, 0);
        chk("t2_state", sched_state, 0);
        chk("t2_noreq", req_total - r0, 0);

        // Buttons 1 and 3; WALK 5 cycles after ISSUE, button 0 pressed during WALK.
        button_raw = 4'b1010;
        wait_issue("t3_reach_issue", 20);
        chk("t3_lamp_issue", wait_lamp, 4'b1010);
        chk("t3_count", issue_count, 2);
        button_raw = 4'b1011;
        tick(4);
        chk("t3_waitwalk", sched_state, 2);
        ped_walk = 1'b1;
        tick(1);
        chk("t3_walk", sched_state, 3);
        chk("t3_served", served_mask, 4'b1010);
        chk("t3_lamp_clr", wait_lamp, 0);
        tick(4);
        chk("t3_walk_hold", sched_state, 3);
        chk("t3_lamp_walk", wait_lamp, 0);
        ped_walk = 1'b0;
        tick(1);
        chk("t3_cool", sched_state, 4);
        tick(19);
        chk("t3_cool_end", sched_state, 4);
        tick(1);
        chk("t3_idle", sched_state, 0);
        chk("t3_lamp_idle", wait_lamp, 0);
        button_raw = 4'b0;
        tick(8);

        // Timeout: WAIT_WALK entered one edge after ISSUE, re-issue 64 edges later.
        button_raw = 4'b0001;
        wait_issue("t4_reach_issue", 20);
        chk("t4_count_a", issue_count, 3);
        tick(1);
        chk("t4_waitwalk", sched_state, 2);
        tick(63);
        chk("t4_still_wait", sched_state, 2);
        chk("t4_no_to", walk_timeout, 0);
        chk("t4_lamp_mid", wait_lamp, 4'b0001);
        tick(1);
        chk("t4_reissue", sched_state, 1);
        chk("t4_to_pulse", walk_timeout, 1);
        chk("t4_req", pedestrian_request, 1);
        chk("t4_count_b", issue_count, 4);
        tick(1);
        chk("t4_to_drop", walk_timeout, 0);
        chk("t4_wait2", sched_state, 2);
        ped_walk = 1'b1; button_raw = 4'b0;
        tick(1);
        chk("t4_served", served_mask, 4'b0001);
        ped_walk = 1'b0;
        tick(21);
        chk("t4_idle", sched_state, 0);

        // enable low holds IDLE with lamp lit; raising it issues on the next edge.
        enable = 1'b0;
        r0 = req_total;
        button_raw = 4'b0001;
        tick(12);
        chk("t5_state", sched_state, 0);
        chk("t5_lamp", wait_lamp, 4'b0001);
        chk("t5_noreq", req_total - r0, 0);
        enable = 1'b1;
        tick(1);
        chk("t5_issue", sched_state, 1);
        chk("t5_count", issue_count, 5);

        // Asynchronous reset in WAIT_WALK.
        tick(1);
        chk("t6_waitwalk", sched_state, 2);
        tick(3);
        reset = 1'b1;
        #1;
        chk("t6_rst_state", sched_state, 0);
        chk("t6_rst_lamp", wait_lamp, 0);
        chk("t6_rst_count", issue_count, 0);
        chk("t6_rst_served", served_mask, 0);
        chk("t6_rst_req", pedestrian_request, 0);
        button_raw = 4'b0;
        tick(3);
        reset = 1'b0;
        r0 = req_total;
        tick(15);
        chk("t6_noreq", req_total - r0, 0);
        chk("t6_idle", sched_state, 0);
        button_raw = 4'b0010;
        wait_issue("t6_new_issue", 20);
        chk("t6_count", issue_count, 1);
        chk("t6_lamp", wait_lamp, 4'b0010);

        chk("no_double_req", dbl_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
